// File: rtl/adc_level_meter.sv
// Block-averaging ADC level meter: turns 10-bit samples into a 0..31 bar level
// with a slowly decaying peak-hold marker, driving a 32-segment LED bar graph.
module adc_level_meter #(
    parameter int AVG_LOG2    = 3,
    parameter int HOLD_TICKS  = 6000000,
    parameter int DECAY_TICKS = 600000
) (
    input  logic       clk12MHz,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [9:0] sample,
    output logic [4:0] level,
    output logic [4:0] peak,
    output logic       frame_strobe,
    output logic [7:0] leds1,
    output logic [7:0] leds2,
    output logic [7:0] leds3,
    output logic [7:0] leds4
);

    localparam int ACC_W   = 10 + AVG_LOG2;
    localparam int HOLD_W  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int DECAY_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_TICKS);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_TICKS - 1);

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [4:0]          level_q, level_d;
    logic [4:0]          peak_q, peak_d;
    logic                frame_strobe_q, frame_strobe_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DECAY_W-1:0]  decay_q, decay_d;

    logic [ACC_W-1:0]    sum_full;
    logic                frame;
    logic                decay_tick;
    logic [31:0]         disp;

    // The top five bits of the block sum above the averaging shift are the bar level.
    always_comb begin
        sum_full       = acc_q + ACC_W'(sample);
        frame          = sample_valid && (cnt_q == '1);
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        level_d        = level_q;
        frame_strobe_d = 1'b0;
        if (sample_valid) begin
            if (frame) begin
                acc_d          = '0;
                cnt_d          = '0;
                level_d        = 5'(sum_full >> (AVG_LOG2 + 5));
                frame_strobe_d = 1'b1;
            end else begin
                acc_d = sum_full;
                cnt_d = cnt_q + AVG_LOG2'(1);
            end
        end
    end

    // Decay ticks keep running while peak sits on the level floor, so the
    // decay phase is preserved if the level later drops.
    always_comb begin
        peak_d     = peak_q;
        hold_d     = hold_q;
        decay_d    = decay_q;
        decay_tick = 1'b0;
        if (frame && (level_d >= peak_q)) begin
            peak_d  = level_d;
            hold_d  = HOLD_LOAD;
            decay_d = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end else if (decay_q == DECAY_LAST) begin
            decay_d    = '0;
            decay_tick = 1'b1;
        end else begin
            decay_d = decay_q + DECAY_W'(1);
        end
        if (decay_tick && (peak_q > level_d)) begin
            peak_d = peak_q - 5'd1;
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            acc_q          <= '0;
            cnt_q          <= '0;
            level_q        <= '0;
            peak_q         <= '0;
            frame_strobe_q <= 1'b0;
            hold_q         <= '0;
            decay_q        <= '0;
        end else begin
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            level_q        <= level_d;
            peak_q         <= peak_d;
            frame_strobe_q <= frame_strobe_d;
            hold_q         <= hold_d;
            decay_q        <= decay_d;
        end
    end

    always_comb begin
        disp = '0;
        for (int i = 0; i < 32; i++) begin
            disp[i] = (6'(i) < {1'b0, level_q}) || ((peak_q != 5'd0) && (peak_q == 5'(i)));
        end
    end

    assign level        = level_q;
    assign peak         = peak_q;
    assign frame_strobe = frame_strobe_q;
    assign leds1        = disp[7:0];
    assign leds2        = disp[15:8];
    assign leds3        = disp[23:16];
    assign leds4        = disp[31:24];

endmodule

// File: tb/tb_adc_level_meter.sv
// Randomised and directed bench for adc_level_meter, checked against a
// cycle-level behavioural model of averaging, peak hold and decay.
module tb_adc_level_meter;

    localparam int AVG_LOG2    = 3;
    localparam int HOLD_TICKS  = 20;
    localparam int DECAY_TICKS = 4;
    localparam int BLOCK       = 1 << AVG_LOG2;

    logic       clk12MHz;
    logic       reset;
    logic       sample_valid;
    logic [9:0] sample;
    logic [4:0] level;
    logic [4:0] peak;
    logic       frame_strobe;
    logic [7:0] leds1, leds2, leds3, leds4;

    int checks;
    int errors;
    int strobe_cnt;

    adc_level_meter #(
        .AVG_LOG2   (AVG_LOG2),
        .HOLD_TICKS (HOLD_TICKS),
        .DECAY_TICKS(DECAY_TICKS)
    ) dut (
        .clk12MHz    (clk12MHz),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample      (sample),
        .level       (level),
        .peak        (peak),
        .frame_strobe(frame_strobe),
        .leds1       (leds1),
        .leds2       (leds2),
        .leds3       (leds3),
        .leds4       (leds4)
    );

    initial clk12MHz = 1'b0;
    always #5 clk12MHz = ~clk12MHz;

    // Reference model: a block sum with a sample count, and a peak whose decay
    // ticks fall at fixed distances from the last time the peak was set.
    int     m_acc, m_cnt, m_level, m_peak, m_strobe;
    longint cyc, set_cyc, elapsed;
    bit     m_tick, m_frame;

    initial begin
        m_acc = 0; m_cnt = 0; m_level = 0; m_peak = 0; m_strobe = 0;
        cyc = 0; set_cyc = -HOLD_TICKS;
    end

    always @(posedge clk12MHz) begin
        cyc++;
        m_strobe = 0;
        if (reset) begin
            m_acc = 0; m_cnt = 0; m_level = 0; m_peak = 0;
            set_cyc = cyc - HOLD_TICKS;
        end else begin
            elapsed = cyc - set_cyc;
            m_tick  = (elapsed > HOLD_TICKS) && (((elapsed - HOLD_TICKS) % DECAY_TICKS) == 0);
            m_frame = 0;
            if (sample_valid) begin
                m_acc += int'(sample);
                m_cnt++;
                if (m_cnt == BLOCK) begin
                    m_level  = (m_acc / BLOCK) / 32;
                    m_acc    = 0;
                    m_cnt    = 0;
                    m_frame  = 1;
                    m_strobe = 1;
                end
            end
            if (m_frame && m_level >= m_peak) begin
                m_peak  = m_level;
                set_cyc = cyc;
            end else if (m_tick && m_peak > m_level) begin
                m_peak--;
            end
        end
    end

    always @(negedge clk12MHz) if (frame_strobe === 1'b1) strobe_cnt++;

    function automatic logic [31:0] model_disp(input int lvl, input int pk);
        logic [31:0] d;
        for (int i = 0; i < 32; i++) d[i] = (i < lvl) || (pk != 0 && i == pk);
        return d;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_reset();
        @(negedge clk12MHz);
        reset        = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk12MHz);
        reset = 1'b0;
    endtask

    // Feeds one block; returns at the negedge right after the completing sample.
    task automatic drive_block(input logic [9:0] vals [BLOCK], input int gap);
        for (int i = 0; i < BLOCK; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    @(negedge clk12MHz);
                    sample_valid = 1'b0;
                end
            end
            @(negedge clk12MHz);
            sample_valid = 1'b1;
            sample       = vals[i];
        end
        @(negedge clk12MHz);
        sample_valid = 1'b0;
    endtask

    task automatic drive_const(input logic [9:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk12MHz);
            sample_valid = 1'b1;
            sample       = v;
        end
        @(negedge clk12MHz);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk12MHz);
        reset        = 1'b1;
        sample_valid = 1'b1;
        sample       = 10'd1023;
        repeat (3) @(negedge clk12MHz);
        checks++;
        if ({level, peak, frame_strobe, leds4, leds3, leds2, leds1} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got level=%0d peak=%0d strobe=%0b leds=%h, expected all zero",
                     level, peak, frame_strobe, {leds4, leds3, leds2, leds1});
        end
        reset        = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk12MHz);
        checks++;
        if (level !== 5'd0 || peak !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_release: got level=%0d peak=%0d, expected 0/0", level, peak);
        end
    endtask

    task automatic test_full_scale();
        drive_const(10'd1023, BLOCK);
        checks++;
        if (frame_strobe !== 1'b1 || level !== 5'd31 || peak !== 5'd31 ||
            {leds4, leds3, leds2, leds1} !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL full_scale: got strobe=%0b level=%0d peak=%0d leds=%h, expected 1/31/31/ffffffff",
                     frame_strobe, level, peak, {leds4, leds3, leds2, leds1});
        end
        @(negedge clk12MHz);
        checks++;
        if (frame_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL strobe_width: got strobe=%0b, expected 0", frame_strobe);
        end
    endtask

    task automatic test_hold_decay();
        drive_const(10'd0, BLOCK);
        checks++;
        if (level !== 5'd0 || peak !== 5'd31 || leds4[7] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_frame: got level=%0d peak=%0d leds4=%h, expected 0/31/1xxxxxxx",
                     level, peak, leds4);
        end
        for (int i = 0; i < 150; i++) begin
            @(negedge clk12MHz);
            checks++;
            if (peak !== 5'(m_peak) || {leds4, leds3, leds2, leds1} !== model_disp(m_level, m_peak)) begin
                errors++;
                $display("[TB] FAIL decay_cycle%0d: got peak=%0d leds=%h, expected peak=%0d leds=%h",
                         i, peak, {leds4, leds3, leds2, leds1}, m_peak, model_disp(m_level, m_peak));
            end
        end
        checks++;
        if (peak !== 5'd0 || {leds4, leds3, leds2, leds1} !== 32'd0) begin
            errors++;
            $display("[TB] FAIL decay_end: got peak=%0d leds=%h, expected 0/0", peak, {leds4, leds3, leds2, leds1});
        end
    endtask

    task automatic test_ramp();
        logic [9:0] vals [BLOCK];
        for (int i = 0; i < BLOCK; i++) vals[i] = 10'(32 * i);
        apply_reset();
        drive_block(vals, 0);
        checks++;
        if (level !== 5'd3 || peak !== 5'd3 || leds1 !== 8'h0F || {leds4, leds3, leds2} !== 24'd0) begin
            errors++;
            $display("[TB] FAIL ramp: got level=%0d peak=%0d leds=%h, expected 3/3/0000000f",
                     level, peak, {leds4, leds3, leds2, leds1});
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] vals [BLOCK];
        logic [4:0] lvl_a, pk_a;
        for (int i = 0; i < BLOCK; i++) vals[i] = 10'($urandom_range(0, 1023));
        apply_reset();
        strobe_cnt = 0;
        drive_block(vals, 0);
        lvl_a = level;
        pk_a  = peak;
        repeat (3) @(negedge clk12MHz);
        checks++;
        if (strobe_cnt !== 1 || lvl_a !== 5'(m_level)) begin
            errors++;
            $display("[TB] FAIL b2b_block: got strobes=%0d level=%0d, expected 1/%0d", strobe_cnt, lvl_a, m_level);
        end
        apply_reset();
        strobe_cnt = 0;
        drive_block(vals, 5);
        repeat (3) @(negedge clk12MHz);
        checks++;
        if (strobe_cnt !== 1 || level !== lvl_a || peak !== pk_a) begin
            errors++;
            $display("[TB] FAIL gapped_block: got strobes=%0d level=%0d peak=%0d, expected 1/%0d/%0d",
                     strobe_cnt, level, peak, lvl_a, pk_a);
        end
    endtask

    task automatic test_reset_partial();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk12MHz);
            sample_valid = 1'b1;
            sample       = 10'd1023;
        end
        apply_reset();
        drive_const(10'd512, BLOCK);
        checks++;
        if (level !== 5'd16 || peak !== 5'd16 || frame_strobe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL partial_discard: got level=%0d peak=%0d strobe=%0b, expected 16/16/1",
                     level, peak, frame_strobe);
        end
    endtask

    task automatic test_decay_floor();
        apply_reset();
        drive_const(10'd1023, BLOCK);
        repeat (30) @(negedge clk12MHz);
        drive_const(10'd640, BLOCK);
        checks++;
        if (level !== 5'd20 || peak !== 5'(m_peak) || peak <= 5'd20) begin
            errors++;
            $display("[TB] FAIL floor_frame: got level=%0d peak=%0d, expected 20/%0d", level, peak, m_peak);
        end
        repeat (100) @(negedge clk12MHz);
        checks++;
        if (peak !== 5'd20 || level !== 5'd20) begin
            errors++;
            $display("[TB] FAIL floor_stop: got level=%0d peak=%0d, expected 20/20", level, peak);
        end
        drive_const(10'd800, BLOCK);
        checks++;
        if (level !== 5'd25 || peak !== 5'd25) begin
            errors++;
            $display("[TB] FAIL reset_hold: got level=%0d peak=%0d, expected 25/25", level, peak);
        end
        drive_const(10'd0, BLOCK);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk12MHz);
            checks++;
            if (peak !== 5'(m_peak) || level !== 5'(m_level)) begin
                errors++;
                $display("[TB] FAIL rehold_cycle%0d: got level=%0d peak=%0d, expected %0d/%0d",
                         i, level, peak, m_level, m_peak);
            end
        end
    endtask

    task automatic test_random();
        int hi;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk12MHz);
            checks++;
            if ({level, peak, frame_strobe} !== {5'(m_level), 5'(m_peak), 1'(m_strobe)} ||
                {leds4, leds3, leds2, leds1} !== model_disp(m_level, m_peak)) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got level=%0d peak=%0d strobe=%0b leds=%h, expected %0d/%0d/%0d/%h",
                         i, level, peak, frame_strobe, {leds4, leds3, leds2, leds1},
                         m_level, m_peak, m_strobe, model_disp(m_level, m_peak));
            end
            hi           = ((i / 250) % 2 == 0) ? 1023 : 300;
            reset        = ($urandom_range(0, 299) == 0);
            sample_valid = ($urandom_range(0, 2) != 0);
            sample       = 10'($urandom_range(0, hi));
        end
        @(negedge clk12MHz);
        reset        = 1'b0;
        sample_valid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        strobe_cnt   = 0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample       = 10'd0;
        $display("[TB] starting adc_level_meter bench");
        test_reset();
        test_full_scale();
        test_hold_decay();
        test_ramp();
        test_back_to_back();
        test_reset_partial();
        test_decay_floor();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
